seq_det_param: RTL

Parametrised successor to the fixed 1011 serial sequence detector. Detects a runtime-programmable PAT_W-bit pattern on a qualified serial bit stream. Overlapping or non-overlapping detection is selectable at runtime, and a saturating match counter is maintained. Sits between a serial source (in_d/in_valid) and downstream logic that consumes the dout pulse or reads match_cnt.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_det_sat_cnt.sv | 28 ++
 rtl/seq_det_param.sv | 89 ++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

  typedef enum {MODE_NONOVL = 0, MODE_OVL = 1} seq_mode_e;

  localparam int unsigned PAT_W_MAX = 32;
  localparam int unsigned CNT_W_MAX = 32;

  // Increment cnt, holding at 2^width-1 instead of wrapping.
  function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] cnt,
                                                   input int unsigned width);
    logic [CNT_W_MAX:0] lim;
    lim = ((CNT_W_MAX+1)'(1) << width) - 1'b1;
    return ({1'b0, cnt} >= lim) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter: clr has priority over inc; holds at all-ones.
module seq_det_sat_cnt
  import seq_det_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W_MAX-1:0] cnt_ext;

  assign cnt_ext = CNT_W_MAX'(cnt);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(cnt_ext, CNT_W));
    end
  end

endmodule

// File: rtl/seq_det_param.sv
// Runtime-programmable PAT_W-bit serial pattern detector with overlap select
// and saturating match counter. Optional don't-care mask: SEQ_DET_MASK_EN.
module seq_det_param
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             mode_ovl,
  input  logic [PAT_W-1:0] pat,
`ifdef SEQ_DET_MASK_EN
  input  logic [PAT_W-1:0] pat_mask,
`endif
  input  logic             in_valid,
  input  logic             in_d,
  output logic             dout,
  output logic             armed,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_NEAR = FILL_W'(PAT_W - 1);

  generate
    if (PAT_W < 2 || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
      $error("seq_det_param: PAT_W out of range 2..32");
    end
    if (CNT_W < 1 || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
      $error("seq_det_param: CNT_W out of range 1..32");
    end
  endgenerate

  // Only the newest PAT_W-1 bits can contribute to a future window, so the
  // oldest bit of the PAT_W history is never stored.
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  hist_nx;
  logic [PAT_W-1:0]  cmp_mask;
  logic              match;
  seq_mode_e         mode;

`ifdef SEQ_DET_MASK_EN
  assign cmp_mask = pat_mask;
`else
  assign cmp_mask = '1;
`endif

  assign mode    = seq_mode_e'(mode_ovl);
  assign hist_nx = {hist, in_d};
  assign match   = in_valid && (fill >= FILL_NEAR) && (((hist_nx ^ pat) & cmp_mask) == '0);
  assign armed   = (fill == FILL_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
      dout <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      dout <= 1'b0;
    end else if (in_valid) begin
      hist <= hist_nx[PAT_W-2:0];
      dout <= match;
      if (match && mode == MODE_NONOVL) begin
        fill <= '0;
      end else if (fill != FILL_FULL) begin
        fill <= fill + 1'b1;
      end
    end else begin
      dout <= 1'b0;
    end
  end

  seq_det_sat_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (match),
    .cnt (match_cnt)
  );

endmodule
